param_adder_seq: RTL

PARAM_ADDER_SEQ -- requirements
Module: param_adder_seq

---
 rtl/param_adder_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/param_adder_seq.sv
// Frame accumulator: sums NUM_INPUTS signed samples per frame and holds the sum until consumed.
// Define PARAM_ADDER_SEQ_SAT_EN to saturate the output and expose sat_flag instead of wrapping.
module param_adder_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         abort,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH:0]   out_data,
    output logic                         busy
`ifdef PARAM_ADDER_SEQ_SAT_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam int ACC_W = DATA_WIDTH + 8;
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                    state, state_nxt;
    logic signed [ACC_W-1:0]   acc, acc_nxt, sum, sample_ext;
    logic        [CNT_W-1:0]   count, count_nxt, count_inc;
    logic                      take, load_out;

`ifdef PARAM_ADDER_SEQ_SAT_EN
    logic sat_q;

    // The sum fits DATA_WIDTH+1 bits exactly when all bits above the output sign agree.
    function automatic logic fits(input logic signed [ACC_W-1:0] a);
        return (a[ACC_W-1:DATA_WIDTH] == '0) || (a[ACC_W-1:DATA_WIDTH] == '1);
    endfunction

    function automatic logic signed [DATA_WIDTH:0] narrow(input logic signed [ACC_W-1:0] a);
        if (fits(a))
            return a[DATA_WIDTH:0];
        else if (a[ACC_W-1])
            return {1'b1, {DATA_WIDTH{1'b0}}};
        else
            return {1'b0, {DATA_WIDTH{1'b1}}};
    endfunction
`else
    function automatic logic signed [DATA_WIDTH:0] narrow(input logic signed [ACC_W-1:0] a);
        return a[DATA_WIDTH:0];
    endfunction
`endif

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        count_nxt  = count;
        load_out   = 1'b0;
        in_ready   = (state != HOLD);
        out_valid  = (state == HOLD);
        busy       = (state == ACCUM);
        take       = in_valid && in_ready;
        count_inc  = count + 1'b1;
        sample_ext = {{8{in_data[DATA_WIDTH-1]}}, in_data};
        // A new frame starts from zero rather than the previous frame's sum.
        sum        = ((state == ACCUM) ? acc : '0) + sample_ext;

        case (state)
            IDLE, ACCUM: begin
                if (take) begin
                    acc_nxt   = sum;
                    count_nxt = count_inc;
                    if (count_inc == LAST) begin
                        state_nxt = HOLD;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            count_nxt = '0;
            load_out  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
`ifdef PARAM_ADDER_SEQ_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            if (load_out) begin
                out_data <= narrow(acc_nxt);
`ifdef PARAM_ADDER_SEQ_SAT_EN
                sat_q    <= !fits(acc_nxt);
`endif
            end
        end
    end

`ifdef PARAM_ADDER_SEQ_SAT_EN
    assign sat_flag = sat_q && out_valid;
`endif

endmodule
